// File: rtl/si_alu_defs.sv
// Shared definitions for the single-issue execute stage: ALU opcode encoding,
// execute-controller FSM states and the writeback-class decode helper.
package si_alu_defs;

   typedef enum logic [4:0] {
      ALU_OP_NOP   = 5'd0,
      ALU_OP_ADD   = 5'd1,
      ALU_OP_MUL   = 5'd2,
      ALU_OP_BNE   = 5'd3,
      ALU_OP_JAL   = 5'd4,
      ALU_OP_LUI   = 5'd5,
      ALU_OP_AUIPC = 5'd6,
      ALU_OP_AND   = 5'd7,
      ALU_OP_SLL   = 5'd8,
      ALU_OP_SLT   = 5'd9,
      ALU_OP_BLT   = 5'd10
   } alu_op_e;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } exu_state_e;

   // Single-cycle ops that produce a register result; MUL writes back through its own path.
   function automatic logic op_writes(input logic [4:0] op);
      case (op)
         ALU_OP_ADD, ALU_OP_AND, ALU_OP_SLL, ALU_OP_SLT,
         ALU_OP_LUI, ALU_OP_AUIPC, ALU_OP_JAL: op_writes = 1'b1;
         default:                               op_writes = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/si_mul_iter.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, DW cycles per product.
// The last step is folded into the combinational product so done and product coincide.
module si_mul_iter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          done,
   output logic [DW-1:0] product
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST = CW'(DW - 1);

   logic [DW-1:0] mcand;
   logic [DW-1:0] mplier;
   logic [DW-1:0] acc;
   logic [DW-1:0] acc_next;
   logic [CW-1:0] count;
   logic          busy;

   assign acc_next = acc + (mplier[0] ? mcand : '0);
   assign product  = acc_next;
   assign done     = busy & (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b0;
      end else if (abort) begin
         count <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (count == LAST) begin
            count <= '0;
            busy  <= 1'b0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/si_exu_ctrl.sv
// Execute-stage sequencer: issues single-cycle ops to the external si_alu, runs MUL on
// si_mul_iter, resolves branches and registers one-cycle writeback/redirect pulses.
module si_exu_ctrl
   import si_alu_defs::*;
#(
   parameter int INST_AW  = 32,
   parameter int REG_DW   = 32,
   parameter int ALUOP_DW = 5,
   parameter int RD_AW    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                issue_valid_i,
   output logic                issue_ready_o,
   input  logic [ALUOP_DW-1:0] issue_opcode_i,
   input  logic [REG_DW-1:0]   issue_op1_i,
   input  logic [REG_DW-1:0]   issue_op2_i,
   input  logic [INST_AW-1:0]  issue_imm_i,
   input  logic [INST_AW-1:0]  issue_pc_i,
   input  logic [RD_AW-1:0]    issue_rd_i,
   input  logic                flush_i,
   output logic [ALUOP_DW-1:0] alu_opcode_o,
   output logic [REG_DW-1:0]   alu_op1_o,
   output logic [REG_DW-1:0]   alu_op2_o,
   output logic [INST_AW-1:0]  alu_pc_o,
   output logic                alu_branch_en_o,
   output logic                alu_jump_en_o,
   output logic [INST_AW-1:0]  alu_offset_o,
   input  logic [REG_DW-1:0]   alu_result_i,
   input  logic                alu_ctrl_en_i,
   input  logic [INST_AW-1:0]  alu_ctrl_pc_i,
   output logic                wb_valid_o,
   output logic [RD_AW-1:0]    wb_rd_o,
   output logic [REG_DW-1:0]   wb_data_o,
   output logic                redirect_valid_o,
   output logic [INST_AW-1:0]  redirect_pc_o,
   output logic                busy_o
);

   exu_state_e        state;
   logic [4:0]        op;
   logic              accept;
   logic              taken;
   logic              mul_start;
   logic              mul_abort;
   logic              mul_done;
   logic [REG_DW-1:0] mul_product;
   logic [RD_AW-1:0]  mul_rd;

   assign op            = issue_opcode_i[4:0];
   assign issue_ready_o = rst & (state == IDLE) & ~redirect_valid_o & ~flush_i;
   assign accept        = issue_valid_i & issue_ready_o;
   assign busy_o        = (state == MUL_BUSY);

   // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      taken = 1'b0;
      case (op)
         ALU_OP_BNE: taken = (issue_op1_i != issue_op2_i);
         ALU_OP_BLT: taken = ($signed(issue_op1_i) < $signed(issue_op2_i));
         default:    taken = 1'b0;
      endcase
   end

   assign alu_opcode_o    = accept ? issue_opcode_i : '0;
   assign alu_op1_o       = issue_op1_i;
   assign alu_op2_o       = issue_op2_i;
   assign alu_pc_o        = issue_pc_i;
   assign alu_offset_o    = issue_imm_i;
   assign alu_branch_en_o = accept & taken;
   assign alu_jump_en_o   = accept & (op == ALU_OP_JAL);

   assign mul_start = accept & (op == ALU_OP_MUL);
   assign mul_abort = flush_i & (state == MUL_BUSY);

   si_mul_iter #(.DW(REG_DW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .abort   (mul_abort),
      .a       (issue_op1_i),
      .b       (issue_op2_i),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         mul_rd           <= '0;
         wb_valid_o       <= 1'b0;
         wb_rd_o          <= '0;
         wb_data_o        <= '0;
         redirect_valid_o <= 1'b0;
         redirect_pc_o    <= '0;
      end else begin
         wb_valid_o       <= 1'b0;
         redirect_valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (mul_start) begin
                  mul_rd <= issue_rd_i;
                  state  <= MUL_BUSY;
               end else if (accept) begin
                  wb_valid_o       <= op_writes(op) & (issue_rd_i != '0);
                  wb_rd_o          <= issue_rd_i;
                  wb_data_o        <= (op == ALU_OP_JAL) ? REG_DW'(issue_pc_i + INST_AW'(4))
                                                         : alu_result_i;
                  redirect_valid_o <= (alu_branch_en_o | alu_jump_en_o) & alu_ctrl_en_i;
                  redirect_pc_o    <= alu_ctrl_pc_i;
               end
            end
            MUL_BUSY: begin
               // Flush wins over a finishing multiply: the product is dropped.
               if (flush_i) begin
                  state <= IDLE;
               end else if (mul_done) begin
                  wb_valid_o <= (mul_rd != '0);
                  wb_rd_o    <= mul_rd;
                  wb_data_o  <= mul_product;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
